// File: rtl/tetris_game_ctrl.sv
// Game-flow controller for the Tetris datapath: start, spawn, gravity fall, lock, line clear.
// Optional soft-drop gravity is enabled by defining SOFT_DROP_EN.
module tetris_game_ctrl #(
  parameter int unsigned ROWS            = 20,
  parameter int unsigned DROP_TICKS      = 25000000,
  parameter int unsigned LINES_W         = 16,
  parameter int unsigned SOFT_DROP_TICKS = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start_game,
  input  logic                     pause,
`ifdef SOFT_DROP_EN
  input  logic                     soft_drop,
`endif
  input  logic                     filled_under,
  input  logic                     spawn_blocked,
  input  logic [ROWS-1:0]          completed_lines,
  input  logic                     shift_done,
  output logic                     load_block,
  output logic                     drop_block,
  output logic                     update_board_state,
  output logic                     shift_down,
  output logic [$clog2(ROWS)-1:0]  clear_row,
  output logic [LINES_W-1:0]       lines_cleared,
  output logic                     playing,
  output logic                     game_over
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned CntW = $clog2(DROP_TICKS);

  typedef enum logic [3:0] {
    StIdle, StStartWait, StSpawn, StSpawnCheck, StFall,
    StPaused, StLock, StCheckLines, StClear, StGameOver
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [RowW-1:0]    low_idx;
  logic [CntW-1:0]    term_cnt;
  logic               soft_sel;
  logic               drop_fire;

`ifdef SOFT_DROP_EN
  assign soft_sel = soft_drop;
`else
  assign soft_sel = 1'b0;
`endif

  assign term_cnt = soft_sel ? CntW'(SOFT_DROP_TICKS - 1) : CntW'(DROP_TICKS - 1);

  // Descending scan so the lowest full row wins.
  always_comb begin
    low_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (completed_lines[r]) low_idx = RowW'(r);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    lines_d   = lines_q;
    drop_fire = 1'b0;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_game) begin
          state_d = StStartWait;
          lines_d = '0;
        end
      end
      StStartWait: if (!start_game) state_d = StSpawn;
      StSpawn:     state_d = StSpawnCheck;
      StSpawnCheck: begin
        if (spawn_blocked) begin
          state_d = StGameOver;
        end else begin
          state_d = StFall;
          cnt_d   = '0;
        end
      end
      StFall: begin
        if (pause) begin
          state_d = StPaused;
        end else if (cnt_q >= term_cnt) begin
          // >= lets a late soft-drop request fire on the next cycle.
          cnt_d = '0;
          if (filled_under) state_d = StLock;
          else              drop_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPaused: if (!pause) state_d = StFall;
      StLock:   state_d = StCheckLines;
      StCheckLines: begin
        if (|completed_lines) begin
          state_d = StClear;
          row_d   = low_idx;
        end else begin
          state_d = StSpawn;
        end
      end
      StClear: begin
        if (shift_done) begin
          state_d = StCheckLines;
          if (lines_q != '1) lines_d = lines_q + LINES_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      lines_q <= lines_d;
    end
  end

  assign load_block         = (state_q == StSpawn);
  assign drop_block         = drop_fire;
  assign update_board_state = (state_q == StLock);
  assign shift_down         = (state_q == StClear);
  assign clear_row          = row_q;
  assign lines_cleared      = lines_q;
  assign game_over          = (state_q == StGameOver);
  assign playing            = state_q inside {StSpawn, StSpawnCheck, StFall, StPaused,
                                              StLock, StCheckLines, StClear};

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Self-checking bench for tetris_game_ctrl: vector table, directed corner cases and a
// randomized run against a cycle-level reference model of the game rules.
module tb_tetris_game_ctrl;
  localparam int unsigned ROWS = 20;
  localparam int unsigned DROP = 4;
  localparam int unsigned LW   = 3;
  localparam int unsigned SOFT = 2;
  localparam int unsigned RW   = $clog2(ROWS);

  localparam int M_IDLE = 0, M_WAIT = 1, M_SPAWN = 2, M_CHECK = 3, M_FALL = 4;
  localparam int M_PAUSE = 5, M_LOCK = 6, M_LINES = 7, M_CLEAR = 8, M_OVER = 9;

  logic clock = 1'b0;
  logic resetn, start_game, pause, filled_under, spawn_blocked, shift_done;
`ifdef SOFT_DROP_EN
  logic soft_drop;
`endif
  logic [ROWS-1:0] completed_lines;
  logic load_block, drop_block, update_board_state, shift_down, playing, game_over;
  logic [RW-1:0] clear_row;
  logic [LW-1:0] lines_cleared;

  always #5 clock = ~clock;

  tetris_game_ctrl #(
    .ROWS(ROWS), .DROP_TICKS(DROP), .LINES_W(LW), .SOFT_DROP_TICKS(SOFT)
  ) dut (
    .clock(clock), .resetn(resetn), .start_game(start_game), .pause(pause),
`ifdef SOFT_DROP_EN
    .soft_drop(soft_drop),
`endif
    .filled_under(filled_under), .spawn_blocked(spawn_blocked),
    .completed_lines(completed_lines), .shift_done(shift_done),
    .load_block(load_block), .drop_block(drop_block),
    .update_board_state(update_board_state), .shift_down(shift_down),
    .clear_row(clear_row), .lines_cleared(lines_cleared),
    .playing(playing), .game_over(game_over)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: game phase, cycles elapsed in the current gravity step, row, score.
  int m_mode = M_IDLE, m_el = 0, m_row = 0, m_lines = 0;

  function automatic logic soft_eff();
`ifdef SOFT_DROP_EN
    return soft_drop;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int period();
    return soft_eff() ? int'(SOFT) : int'(DROP);
  endfunction

  function automatic logic [31:0] model_out();
    logic [5:0] f;
    f[5] = (m_mode == M_SPAWN);
    f[4] = (m_mode == M_FALL) && !pause && (m_el + 1 >= period()) && !filled_under;
    f[3] = (m_mode == M_LOCK);
    f[2] = (m_mode == M_CLEAR);
    f[1] = (m_mode >= M_SPAWN) && (m_mode <= M_CLEAR);
    f[0] = (m_mode == M_OVER);
    return {18'd0, f, RW'(m_row), LW'(m_lines)};
  endfunction

  function automatic logic [31:0] dut_out();
    return {18'd0, load_block, drop_block, update_board_state, shift_down, playing, game_over,
            clear_row, lines_cleared};
  endfunction

  task automatic model_step();
    logic [ROWS-1:0] iso;
    case (m_mode)
      M_IDLE, M_OVER: if (start_game) begin m_mode = M_WAIT; m_lines = 0; end
      M_WAIT:  if (!start_game) m_mode = M_SPAWN;
      M_SPAWN: m_mode = M_CHECK;
      M_CHECK: begin m_mode = spawn_blocked ? M_OVER : M_FALL; m_el = 0; end
      M_FALL: begin
        if (pause) m_mode = M_PAUSE;
        else if (m_el + 1 >= period()) begin
          m_el = 0;
          if (filled_under) m_mode = M_LOCK;
        end else m_el++;
      end
      M_PAUSE: if (!pause) m_mode = M_FALL;
      M_LOCK:  m_mode = M_LINES;
      M_LINES: begin
        if (completed_lines != '0) begin
          iso    = completed_lines & (-completed_lines);
          m_row  = $clog2(iso);
          m_mode = M_CLEAR;
        end else m_mode = M_SPAWN;
      end
      M_CLEAR: if (shift_done) begin
        if (m_lines < (1 << LW) - 1) m_lines++;
        m_mode = M_LINES;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Observed outputs of the last cycle, plus a simple board-datapath emulation.
  logic o_load, o_drop, o_upd, o_shift, o_play, o_over, prev_shift;
  logic [RW-1:0] o_row;
  logic [LW-1:0] o_lines;
  bit auto_dp = 0;
  int sd_cnt = 0;
  int ep_rows[$];

  // Called at the falling edge with inputs set; compares, clocks, returns at next falling edge.
  task automatic cycle();
    logic was_clear, fired;
    if (auto_dp) shift_done = (m_mode == M_CLEAR) && (sd_cnt == 3);
    #1;
    check($sformatf("outputs@%0t", $time), dut_out(), model_out());
    {o_load, o_drop, o_upd, o_shift, o_play, o_over} =
      {load_block, drop_block, update_board_state, shift_down, playing, game_over};
    o_row = clear_row;
    o_lines = lines_cleared;
    if (shift_down && !prev_shift) ep_rows.push_back(int'(clear_row));
    prev_shift = shift_down;
    was_clear = (m_mode == M_CLEAR);
    fired = shift_done;
    @(posedge clock);
    model_step();
    @(negedge clock);
    if (auto_dp) begin
      if (fired) begin
        completed_lines = completed_lines & (completed_lines - ROWS'(1));
        sd_cnt = 0;
      end else if (was_clear) sd_cnt++;
      else sd_cnt = 0;
    end
  endtask

  task automatic async_reset(input string name);
    resetn = 1'b0;
    #1;
    check(name, dut_out(), 32'd0);
    m_mode = M_IDLE; m_el = 0; m_row = 0; m_lines = 0;
    sd_cnt = 0; prev_shift = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  typedef struct packed {
    logic       start;
    logic       filled;
    logic [5:0] exp;   // {load, drop, update, shift, playing, game_over}
  } vec_t;

  vec_t vt[20];
  int idx;
  bit seen;

  initial begin
    resetn = 1'b0; start_game = 0; pause = 0; filled_under = 0; spawn_blocked = 0;
    shift_done = 0; completed_lines = '0; prev_shift = 0;
`ifdef SOFT_DROP_EN
    soft_drop = 0;
`endif
    @(negedge clock);
    #1;
    check("reset_state", dut_out(), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Start, spawn, two gravity steps, then lock with no full rows and respawn.
    vt[0] = '{1'b1, 1'b0, 6'b000000};  vt[1] = '{1'b1, 1'b0, 6'b000000};
    vt[2] = '{1'b0, 1'b0, 6'b000000};  vt[3] = '{1'b0, 1'b0, 6'b100010};
    vt[4] = '{1'b0, 1'b0, 6'b000010};  vt[5] = '{1'b0, 1'b0, 6'b000010};
    vt[6] = '{1'b0, 1'b0, 6'b000010};  vt[7] = '{1'b0, 1'b0, 6'b000010};
    vt[8] = '{1'b0, 1'b0, 6'b010010};  vt[9] = '{1'b1, 1'b0, 6'b000010};
    vt[10] = '{1'b0, 1'b0, 6'b000010}; vt[11] = '{1'b0, 1'b0, 6'b000010};
    vt[12] = '{1'b0, 1'b0, 6'b010010}; vt[13] = '{1'b0, 1'b1, 6'b000010};
    vt[14] = '{1'b0, 1'b1, 6'b000010}; vt[15] = '{1'b0, 1'b1, 6'b000010};
    vt[16] = '{1'b0, 1'b1, 6'b000010}; vt[17] = '{1'b0, 1'b0, 6'b001010};
    vt[18] = '{1'b0, 1'b0, 6'b000010}; vt[19] = '{1'b0, 1'b0, 6'b100010};
    for (int i = 0; i < 20; i++) begin
      start_game = vt[i].start;
      filled_under = vt[i].filled;
      cycle();
      check($sformatf("vec%0d", i), 32'({o_load, o_drop, o_upd, o_shift, o_play, o_over}),
            32'(vt[i].exp));
    end
    start_game = 0;

    // Lock onto rows 0 and 2; datapath answers each shift after three cycles.
    filled_under = 1; completed_lines = 20'h00005; auto_dp = 1; ep_rows.delete();
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = o_load;
    end
    check("clear_reaches_spawn", 32'(seen), 32'd1);
    check("clear_episodes", 32'(ep_rows.size()), 32'd2);
    if (ep_rows.size() == 2) begin
      check("clear_row_first", 32'(ep_rows[0]), 32'd0);
      check("clear_row_second", 32'(ep_rows[1]), 32'd2);
    end
    check("lines_after_clear", 32'(o_lines), 32'd2);
    auto_dp = 0; shift_done = 0;

    // Pause at gravity count 2, hold ten cycles, then resume.
    filled_under = 0;
    cycle(); cycle(); cycle();
    pause = 1; seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (o_drop) seen = 1;
    end
    check("no_drop_while_paused", 32'(seen), 32'd0);
    pause = 0; idx = -1;
    for (int i = 0; i < 8 && idx < 0; i++) begin
      cycle();
      if (o_drop) idx = i;
    end
    check("drop_after_resume", 32'(idx), 32'd2);

    // Blocked spawn ends the game; restart clears the score.
    filled_under = 1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = o_load;
    end
    spawn_blocked = 1;
    cycle();
    cycle();
    check("game_over_flag", 32'({o_over, o_play}), 32'b10);
    check("lines_kept_at_over", 32'(o_lines), 32'd2);
    spawn_blocked = 0; start_game = 1;
    cycle();
    start_game = 0;
    cycle();
    check("lines_zero_on_restart", 32'(o_lines), 32'd0);
    cycle();
    check("respawn_load", 32'(o_load), 32'd1);

    // Reset in the middle of the second clear of a two-row lock.
    completed_lines = 20'h00030; auto_dp = 1;
    for (int i = 0; i < 60 && !(m_mode == M_CLEAR && m_lines == 1); i++) cycle();
    cycle();
    check("clear_row_before_reset", 32'(o_row), 32'd5);
    async_reset("reset_mid_clear");
    auto_dp = 0; shift_done = 0;

    // Full board: clears from row 0 upward and the score saturates.
    start_game = 1; cycle(); start_game = 0; cycle();
    completed_lines = '1; filled_under = 1; auto_dp = 1; ep_rows.delete(); seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cycle();
      seen = o_load && (ep_rows.size() > 0);
    end
    check("full_board_done", 32'(seen), 32'd1);
    check("full_board_episodes", 32'(ep_rows.size()), 32'd20);
    if (ep_rows.size() > 0) check("full_board_first_row", 32'(ep_rows[0]), 32'd0);
    check("lines_saturate", 32'(o_lines), 32'd7);
    auto_dp = 0; shift_done = 0; completed_lines = '0; filled_under = 0;

`ifdef SOFT_DROP_EN
    begin
      int drops[$];
      cycle(); cycle(); cycle();
      soft_drop = 1;
      for (int i = 0; i < 12; i++) begin cycle(); if (o_drop) drops.push_back(i); end
      check("soft_interval", 32'(drops[drops.size()-1] - drops[drops.size()-2]), 32'(SOFT));
      soft_drop = 0; drops.delete();
      for (int i = 0; i < 20; i++) begin cycle(); if (o_drop) drops.push_back(i); end
      check("normal_interval", 32'(drops[drops.size()-1] - drops[drops.size()-2]), 32'(DROP));
    end
`endif

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      start_game = ($urandom_range(3) == 0);
      pause = ($urandom_range(7) == 0);
      filled_under = $urandom_range(1);
      spawn_blocked = ($urandom_range(15) == 0);
      shift_done = ($urandom_range(3) == 0);
      completed_lines = $urandom_range(1) ? '0 : ROWS'($urandom & $urandom & $urandom);
`ifdef SOFT_DROP_EN
      soft_drop = ($urandom_range(2) == 0);
`endif
      if ($urandom_range(499) == 0) async_reset("random_reset");
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
